// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge: memory-mapped I/O responder for the 0xFFFFFC00 window.
// Owns the debounced switches, a sticky button flag, the LED register
// and a time-multiplexed 8-digit seven-segment display.
module mmio_io_bridge #(
  parameter int DB_CYCLES = 100000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] switches,
  input  logic        button,
  output logic [15:0] leds,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cs
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  localparam logic [9:0] OFF_SW  = 10'h000;
  localparam logic [9:0] OFF_BTN = 10'h004;
  localparam logic [9:0] OFF_LED = 10'h010;
  localparam logic [9:0] OFF_SEG = 10'h020;
  localparam logic [9:0] OFF_EN  = 10'h024;

  // Bit 16 of the synchronised/debounced vectors is the button, 15:0 the switches.
  localparam int NIN = 17;

  logic            in_window;
  logic [9:0]      offset;
  logic            rd_hit;
  logic            wr_hit;
  logic            btn_clr;

  logic [NIN-1:0]  sync1;
  logic [NIN-1:0]  sync2;
  logic [NIN-1:0]  db;
  logic [DB_W-1:0] db_cnt [NIN];
  logic            btn_db_q;
  logic            btn_flag;

  logic [15:0]     led_reg;
  logic [31:0]     seg_reg;
  logic [7:0]      en_reg;

  logic [SC_W-1:0] scan_cnt;
  logic [2:0]      digit_idx;
  logic [3:0]      cur_nibble;

  assign in_window  = &addr[31:10];
  assign offset     = addr[9:0];
  assign rd_hit     = io_read && in_window;
  assign wr_hit     = io_write && in_window;
  assign btn_clr    = rd_hit && (offset == OFF_BTN);
  assign leds       = led_reg;
  assign cur_nibble = seg_reg[{digit_idx, 2'b00} +: 4];

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one hex digit, dp off.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p | 8'h80;
  endfunction

  // Two-flop synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {button, switches};
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the debounced bit follows only after DB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Sticky button flag: set by a debounced rising edge, cleared by a BTN read; set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db_q <= 1'b0;
      btn_flag <= 1'b0;
    end else begin
      btn_db_q <= db[16];
      if (db[16] && !btn_db_q) begin
        btn_flag <= 1'b1;
      end else if (btn_clr) begin
        btn_flag <= 1'b0;
      end
    end
  end

  // CPU-writable registers; unmapped offsets and out-of-window stores are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg <= '0;
      seg_reg <= '0;
      en_reg  <= '0;
    end else if (wr_hit) begin
      case (offset)
        OFF_LED: led_reg <= wdata[15:0];
        OFF_SEG: seg_reg <= wdata;
        OFF_EN:  en_reg  <= wdata[7:0];
        default: ;
      endcase
    end
  end

  // Scan timebase: each digit is held for SCAN_DIV cycles before advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SC_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SC_W'(1);
    end
  end

  // Registered display drive for the currently selected digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an <= 8'hFF;
      seg_cs <= 8'hFF;
    end else begin
      seg_an <= ~(en_reg & (8'd1 << digit_idx));
      seg_cs <= hex7(cur_nibble);
    end
  end

  // Combinational load data from the current register state.
  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (offset)
        OFF_SW:  rdata = {16'b0, db[15:0]};
        OFF_BTN: rdata = {31'b0, btn_flag};
        OFF_LED: rdata = {16'b0, led_reg};
        OFF_SEG: rdata = seg_reg;
        OFF_EN:  rdata = {24'b0, en_reg};
        default: rdata = '0;
      endcase
    end
  end

endmodule
